// File: rtl/fp_div_arbiter_pkg.sv
// Shared constants and tag type for the FP divider arbiter and its sibling shared-unit arbiters.
// The tag index is sized for up to eight requesters.
package fp_div_arbiter_pkg;

    localparam logic [31:0] FP_ZERO             = 32'h00000000;
    localparam logic [31:0] FP_ONE              = 32'h3f800000;
    localparam int unsigned DIV_LATENCY_DEFAULT = 6;
    localparam int unsigned TAG_IDX_W           = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
        logic                 den_zero;
    } tag_t;

    // Zero exponent covers both signed zeros and denormals.
    function automatic logic is_den_zero(input logic [31:0] f);
        return f[30:23] == 8'h00;
    endfunction

endpackage

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first unmasked request at or after the pointer, wrapping.
// Reusable for any shared single-issue FP unit.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [NREQ-1:0] eligible;

    assign eligible = req_i & ~mask_i;

    always_comb begin
        int unsigned j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr_i) + i) % NREQ;
            if (!any_o && eligible[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = IDXW'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one fixed-latency pipelined FP divider among NREQ requesters with round-robin issue
// and a tag pipeline that routes each quotient back to its requester.
module fp_div_arbiter
    import fp_div_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int unsigned TAGW        = 3
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic                 iEnable,
    input  logic [NREQ-1:0]      iReq,
    input  logic [NREQ*32-1:0]   iNum,
    input  logic [NREQ*32-1:0]   iDen,
    output logic [NREQ-1:0]      oGrant,
    output logic [31:0]          oDivNum,
    output logic [31:0]          oDivDen,
    output logic                 oDivEnable,
    input  logic [31:0]          iDivQuot,
    output logic [31:0]          oQuot,
    output logic [NREQ-1:0]      oQuotValid,
    output logic                 oDivByZero,
    output logic                 oBusy
);

    // Stage 0 travels with the operand register; stages 1..DIV_LATENCY shadow the divider,
    // so the last stage is valid exactly when iDivQuot holds that operation's quotient.
    localparam int unsigned NSTAGE = DIV_LATENCY + 1;

    logic [TAGW-1:0] ptr_q;
    tag_t            tag_q [NSTAGE];

    logic [NREQ-1:0] arb_grant;
    logic [TAGW-1:0] arb_idx;
    logic            arb_any;
    logic [31:0]     win_num;
    logic [31:0]     win_den;
    tag_t            tag_in;
    logic [NREQ-1:0] ret_onehot;
    logic [TAGW-1:0] ptr_next;

    assign oDivEnable = iEnable;

    // Masking with the current grant stops a re-issue before the requester sees its grant.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (TAGW)
    ) u_rr (
        .req_i   (iReq),
        .mask_i  (oGrant),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        win_num = '0;
        win_den = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                win_num = iNum[32*i +: 32];
                win_den = iDen[32*i +: 32];
            end
        end
        tag_in          = '0;
        tag_in.valid    = arb_any;
        tag_in.idx      = TAG_IDX_W'(arb_idx);
        tag_in.den_zero = arb_any && is_den_zero(win_den);
        ptr_next        = (arb_idx == TAGW'(NREQ - 1)) ? '0 : arb_idx + TAGW'(1);
    end

    always_comb begin
        ret_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ret_onehot[i] = (tag_q[NSTAGE-1].idx == TAG_IDX_W'(i));
        end
    end

    always_comb begin
        oBusy = |oGrant;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            oBusy = oBusy | tag_q[i].valid;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            ptr_q      <= '0;
            oGrant     <= '0;
            oDivNum    <= '0;
            oDivDen    <= '0;
            oQuot      <= '0;
            oQuotValid <= '0;
            oDivByZero <= 1'b0;
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                tag_q[i] <= '0;
            end
        end else if (!iEnable) begin
            oGrant     <= '0;
            oQuotValid <= '0;
            oDivByZero <= 1'b0;
        end else begin
            oGrant   <= arb_grant;
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i < NSTAGE; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (arb_any) begin
                oDivNum <= win_num;
                oDivDen <= win_den;
                ptr_q   <= ptr_next;
            end
            if (tag_q[NSTAGE-1].valid) begin
                oQuot      <= tag_q[NSTAGE-1].den_zero ? FP_ZERO : iDivQuot;
                oQuotValid <= ret_onehot;
                oDivByZero <= tag_q[NSTAGE-1].den_zero;
            end else begin
                oQuotValid <= '0;
                oDivByZero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Scoreboard bench for fp_div_arbiter with a behavioural pipelined divider model.
module tb_fp_div_arbiter;
    import fp_div_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 6;
    localparam int unsigned TAGW = 3;

    logic                 iClock = 1'b0;
    logic                 iReset;
    logic                 iEnable;
    logic [NREQ-1:0]      iReq;
    logic [NREQ*32-1:0]   iNum;
    logic [NREQ*32-1:0]   iDen;
    logic [NREQ-1:0]      oGrant;
    logic [31:0]          oDivNum;
    logic [31:0]          oDivDen;
    logic                 oDivEnable;
    logic [31:0]          iDivQuot;
    logic [31:0]          oQuot;
    logic [NREQ-1:0]      oQuotValid;
    logic                 oDivByZero;
    logic                 oBusy;

    logic [31:0] num_a [NREQ];
    logic [31:0] den_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign iNum[32*g +: 32] = num_a[g];
        assign iDen[32*g +: 32] = den_a[g];
    end

    fp_div_arbiter #(
        .NREQ        (NREQ),
        .DIV_LATENCY (LAT),
        .TAGW        (TAGW)
    ) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iEnable    (iEnable),
        .iReq       (iReq),
        .iNum       (iNum),
        .iDen       (iDen),
        .oGrant     (oGrant),
        .oDivNum    (oDivNum),
        .oDivDen    (oDivDen),
        .oDivEnable (oDivEnable),
        .iDivQuot   (iDivQuot),
        .oQuot      (oQuot),
        .oQuotValid (oQuotValid),
        .oDivByZero (oDivByZero),
        .oBusy      (oBusy)
    );

    always #5 iClock = ~iClock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Exact for power-of-two divisors, plus the 6/3 case; otherwise just a deterministic tag.
    function automatic logic [31:0] div_ref(input logic [31:0] n, input logic [31:0] d);
        if (n == 32'h40C00000 && d == 32'h40400000) return 32'h40000000;
        return {n[31] ^ d[31], n[30:0] - d[30:0] + 31'h3F800000};
    endfunction

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Divider IP model: captures operands on each enabled edge, quotient after LAT edges.
    logic [31:0] div_pipe [LAT];
    always @(posedge iClock) begin
        if (oDivEnable) begin
            div_pipe[0] <= div_ref(oDivNum, oDivDen);
            for (int k = 1; k < LAT; k++) div_pipe[k] <= div_pipe[k-1];
        end
    end
    assign iDivQuot = div_pipe[LAT-1];

    typedef struct {
        int          idx;
        logic [31:0] quot;
        logic        dz;
        int          due;
    } exp_t;

    exp_t            sb [$];
    exp_t            e_push;
    exp_t            e_pop;
    int              en_cnt = 0;
    logic [NREQ-1:0] prev_grant = '0;
    logic [31:0]     last_quot = '0;

    always @(posedge iClock) begin
        if (iReset) en_cnt <= 0;
        else if (iEnable) en_cnt <= en_cnt + 1;
    end

    always @(negedge iClock) begin
        if (iReset) begin
            sb.delete();
            prev_grant = '0;
        end else begin
            if (oGrant != '0) begin
                check_eq("grant_onehot", 32'($onehot(oGrant)), 32'd1);
                check_eq("no_back_to_back", 32'(oGrant & prev_grant), 32'd0);
                e_push.idx  = oh2idx(oGrant);
                e_push.dz   = den_a[e_push.idx][30:23] == 8'h00;
                e_push.quot = e_push.dz ? 32'h0 : div_ref(num_a[e_push.idx], den_a[e_push.idx]);
                e_push.due  = en_cnt + LAT + 1;
                sb.push_back(e_push);
            end
            prev_grant = oGrant;
            if (oQuotValid != '0) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_valid", 32'(oQuotValid), 32'd0);
                end else begin
                    e_pop = sb.pop_front();
                    check_eq("valid_idx", 32'(oQuotValid), 32'd1 << e_pop.idx);
                    check_eq("quot", oQuot, e_pop.quot);
                    check_eq("div_by_zero", 32'(oDivByZero), 32'(e_pop.dz));
                    check_eq("latency", 32'(en_cnt), 32'(e_pop.due));
                    last_quot = e_pop.quot;
                end
            end else if (oDivByZero) begin
                check_eq("dbz_without_valid", 32'(oDivByZero), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        iReq   = '0;
        tick();
        tick();
        iReset = 1'b0;
    endtask

    task automatic wait_grant(input int i);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!oGrant[i] && n < 20);
        if (!oGrant[i]) check_eq("grant_timeout", 32'(oGrant), 32'd1 << i);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || oBusy) && n < 100) begin
            tick();
            n++;
        end
        tick();
        check_eq("drain", {31'(sb.size()), oBusy}, 32'd0);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (oQuotValid == '0 && cycles < 30);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        iReset  = 1'b1;
        iEnable = 1'b1;
        iReq    = '0;
        for (int i = 0; i < NREQ; i++) begin
            num_a[i] = FP_ONE;
            den_a[i] = FP_ONE;
        end
        do_reset();

        check_eq("rst_grant", 32'(oGrant), 32'd0);
        check_eq("rst_qvalid", 32'(oQuotValid), 32'd0);
        check_eq("rst_dbz", 32'(oDivByZero), 32'd0);
        check_eq("rst_busy", 32'(oBusy), 32'd0);
        check_eq("rst_divnum", oDivNum, 32'd0);
        check_eq("rst_divden", oDivDen, 32'd0);
        check_eq("rst_quot", oQuot, 32'd0);

        // Single request 6.0 / 3.0
        num_a[0] = 32'h40C00000;
        den_a[0] = 32'h40400000;
        iReq     = 4'b0001;
        tick();
        check_eq("single_grant", 32'(oGrant), 32'b0001);
        iReq = '0;
        wait_valid(cyc);
        check_eq("single_latency", 32'(cyc), 32'(LAT + 1));
        check_eq("single_valid", 32'(oQuotValid), 32'b0001);
        check_eq("single_quot", oQuot, 32'h40000000);
        drain();
        check_eq("single_idle", 32'(oBusy), 32'd0);

        // All four requesting continuously from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            num_a[i] = FP_ONE + (32'(i) << 23);
            den_a[i] = FP_ONE + (32'(i % 2) << 23);
        end
        iReq = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            tick();
            check_eq("rr_order", 32'(oGrant), 32'd1 << (c % 4));
        end
        iReq = '0;
        drain();

        // Divide by negative zero on requester 2
        num_a[2] = FP_ONE;
        den_a[2] = 32'h80000000;
        iReq     = 4'b0100;
        wait_grant(2);
        iReq = '0;
        wait_valid(cyc);
        check_eq("dbz_valid", 32'(oQuotValid), 32'b0100);
        check_eq("dbz_quot", oQuot, 32'h0);
        check_eq("dbz_flag", 32'(oDivByZero), 32'd1);
        drain();

        // Three-cycle stall with two operations in flight
        num_a[0] = 32'h40800000;
        den_a[0] = 32'h40000000;
        num_a[1] = 32'h41000000;
        den_a[1] = 32'h3F000000;
        iReq     = 4'b0011;
        tick();
        check_eq("stall_grant0", 32'(oGrant), 32'b0001);
        iReq = iReq & ~oGrant;
        tick();
        check_eq("stall_grant1", 32'(oGrant), 32'b0010);
        iReq = '0;
        tick();
        iEnable = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_eq("stall_no_grant", 32'(oGrant), 32'd0);
            check_eq("stall_no_valid", 32'(oQuotValid), 32'd0);
            check_eq("stall_quot_hold", oQuot, last_quot);
            check_eq("stall_busy", 32'(oBusy), 32'd1);
        end
        iEnable = 1'b1;
        cyc = 5;
        do begin
            tick();
            cyc++;
        end while (oQuotValid == '0 && cyc < 40);
        check_eq("stall_delay", 32'(cyc), 32'(LAT + 1 + 3));
        check_eq("stall_first_tag", 32'(oQuotValid), 32'b0001);
        drain();

        // Reset three cycles after a grant
        for (int i = 0; i < NREQ; i++) begin
            num_a[i] = 32'h40000000;
            den_a[i] = FP_ONE;
        end
        iReq = 4'b0010;
        wait_grant(1);
        iReq = '0;
        tick();
        tick();
        tick();
        iReset = 1'b1;
        iReq   = 4'b1011;
        tick();
        tick();
        check_eq("mid_rst_grant", 32'(oGrant), 32'd0);
        check_eq("mid_rst_valid", 32'(oQuotValid), 32'd0);
        check_eq("mid_rst_busy", 32'(oBusy), 32'd0);
        check_eq("mid_rst_divnum", oDivNum, 32'd0);
        check_eq("mid_rst_quot", oQuot, 32'd0);
        iReset = 1'b0;
        tick();
        check_eq("post_rst_grant", 32'(oGrant), 32'b0001);
        iReq = '0;
        drain();

        // Requester 1 withdraws while 0 and 3 alternate
        num_a[0] = 32'h40400000;
        den_a[0] = 32'h40000000;
        num_a[3] = 32'h40E00000;
        den_a[3] = 32'h3E800000;
        num_a[1] = 32'h41200000;
        den_a[1] = FP_ONE;
        iReq     = 4'b1001;
        wait_grant(3);
        iReq = 4'b1011;
        tick();
        check_eq("withdraw_grant0", 32'(oGrant), 32'b0001);
        iReq = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_eq("withdraw_alt", 32'(oGrant), (c % 2 == 0) ? 32'b1000 : 32'b0001);
        end
        iReq = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
